// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Programmable VGA raster timing generator and pixel output stage. Free-running
// x/y counters walk the full raster (active + porches + sync). During the
// active region, pixels are pulled from an upstream FIFO through a ready/valid
// handshake. All pin-facing outputs are registered, so hsync, vsync, de, RGB
// and frame_start describe the counter position of the previous clock and
// stay mutually aligned.
//
// If the FIFO has no pixel during an active cycle, that pixel is blanked and
// the sticky underflow flag is set. The raster never stalls.
//
// Optional feature: define VGA_UNDERFLOW_CNT_EN to add underflow_cnt, a
// 16-bit saturating count of starved pixels that is cleared only by reset.
//
// Ports:
//   clk           pixel clock
//   reset         asynchronous, active-high reset
//   en            run enable; low forces the raster to (0,0) and idles outputs
//   pixel_data    {b,g,r}, r in the LSBs
//   pixel_valid   upstream pixel available
//   pixel_ready   pixel consumed this cycle (combinational: en && active)
//   r, g, b       registered colour, zero outside active video or on starve
//   hsync, vsync  registered syncs, asserted level set by HSYNC_POL/VSYNC_POL
//   de            registered data-enable
//   frame_start   one-cycle pulse aligned with pixel (0,0) on the outputs
//   x, y          current counter position (unregistered)
//   underflow     sticky starvation flag, cleared at frame_start
//   underflow_cnt saturating starved-pixel count (VGA_UNDERFLOW_CNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int COLOR_DEPTH = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int CNT_W       = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [3*COLOR_DEPTH-1:0] pixel_data,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  output logic [COLOR_DEPTH-1:0]   r,
  output logic [COLOR_DEPTH-1:0]   g,
  output logic [COLOR_DEPTH-1:0]   b,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic                     frame_start,
  output logic [CNT_W-1:0]         x,
  output logic [CNT_W-1:0]         y,
  output logic                     underflow
`ifdef VGA_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]              underflow_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width copies of the raster boundaries, so that every comparison
  // below is done at CNT_W bits.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0]         x_cnt;
  logic [CNT_W-1:0]         y_cnt;
  logic [3*COLOR_DEPTH-1:0] rgb_q;

  logic active;
  logic hs_region;
  logic vs_region;
  logic starved;
  logic xfer;
  logic at_origin;

  // Raster decode on the current counter position.
  assign active    = (x_cnt < H_ACT_END) && (y_cnt < V_ACT_END);
  assign hs_region = (x_cnt >= HS_START) && (x_cnt < HS_END);
  assign vs_region = (y_cnt >= VS_START) && (y_cnt < VS_END);

  assign pixel_ready = en && active;
  assign xfer        = pixel_ready && pixel_valid;
  assign starved     = pixel_ready && !pixel_valid;
  // Used for frame_start and for clearing underflow, so that both line up
  // with pixel (0,0) on the outputs.
  assign at_origin   = en && (x_cnt == '0) && (y_cnt == '0);

  assign x = x_cnt;
  assign y = y_cnt;

  // Raster counters. While en is low they are held at the origin, so the
  // first enabled cycle always starts a fresh frame.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (!en) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (x_cnt == H_LAST) begin
      x_cnt <= '0;
      y_cnt <= (y_cnt == V_LAST) ? '0 : y_cnt + CNT_ONE;
    end else begin
      x_cnt <= x_cnt + CNT_ONE;
    end
  end

  // Output stage: one register delay after the counters, so all outputs share
  // the same latency. With en low, every output falls to its idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      rgb_q       <= xfer ? pixel_data : '0;
      hsync       <= (en && hs_region) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (en && vs_region) ? VSYNC_POL : ~VSYNC_POL;
      de          <= pixel_ready;
      frame_start <= at_origin;
      // Starvation at the origin takes priority over the frame clear.
      underflow   <= starved || (underflow && !at_origin);
    end
  end

  assign r = rgb_q[COLOR_DEPTH-1:0];
  assign g = rgb_q[2*COLOR_DEPTH-1:COLOR_DEPTH];
  assign b = rgb_q[3*COLOR_DEPTH-1:2*COLOR_DEPTH];

`ifdef VGA_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_cnt <= '0;
    end else if (starved && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen in a 16x8 raster (H 8/2/3/3, V 4/1/2/1).
// Two instances share stimulus: dut uses active-low syncs, dut_p uses
// active-high syncs.
//
// Each cycle, a behavioural raster model predicts the registered outputs and
// pushes them to a scoreboard queue. They are popped and compared one clock
// later. Counters and pixel_ready are compared in the same cycle they are
// driven.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int CD = 4;
  localparam int CW = 5;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        uf;
    logic [15:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [11:0]   pixel_data;
  logic          pixel_valid;

  logic          pixel_ready, hsync, vsync, de, frame_start, underflow;
  logic [CD-1:0] r, g, b;
  logic [CW-1:0] x, y;

  logic          pixel_ready_p, hsync_p, vsync_p, de_p, frame_start_p, underflow_p;
  logic [CD-1:0] r_p, g_p, b_p;
  logic [CW-1:0] x_p, y_p;

`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt, underflow_cnt_p;
`endif

  vga_timing_gen #(
    .COLOR_DEPTH(CD), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .x(x), .y(y), .underflow(underflow)
`ifdef VGA_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  vga_timing_gen #(
    .COLOR_DEPTH(CD), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CW)
  ) dut_p (
    .clk(clk), .reset(reset), .en(en),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready_p),
    .r(r_p), .g(g_p), .b(b_p), .hsync(hsync_p), .vsync(vsync_p), .de(de_p),
    .frame_start(frame_start_p), .x(x_p), .y(y_p), .underflow(underflow_p)
`ifdef VGA_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt_p)
`endif
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;

  // Model state
  int          mx, my;
  logic        m_uf;
  logic [15:0] m_cnt;
  logic [11:0] data_ctr;
  exp_t        sb[$];
  int          cyc;
  int          de_cnt, xfer_cnt;
  int          fs_times[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_rgb", {20'd0, b, g, r}, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_hsync_p", hsync_p, 0);
    chk("rst_vsync_p", vsync_p, 0);
    chk("rst_rgb_p", {20'd0, b_p, g_p, r_p}, 0);
`ifdef VGA_UNDERFLOW_CNT_EN
    chk("rst_cnt", underflow_cnt, 0);
`endif
  endtask

  // One clock cycle, called at the falling edge.
  task automatic cycle(input logic en_i, input logic val_i);
    exp_t e;
    logic act, starv, fs;
    cyc++;

    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rgb", {20'd0, b, g, r}, {20'd0, e.rgb});
      chk("hsync", hsync, e.hs);
      chk("vsync", vsync, e.vs);
      chk("de", de, e.de);
      chk("frame_start", frame_start, e.fs);
      chk("underflow", underflow, e.uf);
      chk("rgb_p", {20'd0, b_p, g_p, r_p}, {20'd0, e.rgb});
      chk("hsync_p", hsync_p, !e.hs);
      chk("vsync_p", vsync_p, !e.vs);
      chk("de_p", de_p, e.de);
      chk("frame_start_p", frame_start_p, e.fs);
      chk("underflow_p", underflow_p, e.uf);
`ifdef VGA_UNDERFLOW_CNT_EN
      chk("underflow_cnt", underflow_cnt, e.cnt);
      chk("underflow_cnt_p", underflow_cnt_p, e.cnt);
`endif
      if (de !== 1'b1) chk("rgb_blank", {20'd0, b, g, r}, 0);
    end
    if (de === 1'b1) de_cnt++;
    if (frame_start === 1'b1) fs_times.push_back(cyc);

    en          = en_i;
    pixel_valid = val_i;
    pixel_data  = data_ctr;
    #1;

    act   = en_i && (mx < 8) && (my < 4);
    starv = act && !val_i;
    fs    = en_i && (mx == 0) && (my == 0);
    chk("x", x, mx);
    chk("y", y, my);
    chk("pixel_ready", pixel_ready, act);
    chk("x_p", x_p, mx);
    chk("y_p", y_p, my);
    chk("pixel_ready_p", pixel_ready_p, act);
    if (pixel_ready === 1'b1 && pixel_valid) xfer_cnt++;

    e.rgb = (act && val_i) ? data_ctr : 12'h000;
    e.hs  = !(en_i && mx >= 10 && mx <= 12);
    e.vs  = !(en_i && my >= 5 && my <= 6);
    e.de  = act;
    e.fs  = fs;
    if (starv)   m_uf = 1'b1;
    else if (fs) m_uf = 1'b0;
    e.uf  = m_uf;
    if (starv && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    e.cnt = m_cnt;
    sb.push_back(e);

    if (act && val_i) data_ctr = data_ctr + 12'd1;
    if (!en_i) begin
      mx = 0;
      my = 0;
    end else if (mx == 15) begin
      mx = 0;
      my = (my == 7) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int tx, input int ty);
    logic hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mx == tx && my == ty) begin
        hit = 1'b1;
        break;
      end
      cycle(1'b1, 1'b1);
    end
    chk("run_to_reached", hit, 1);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    chk_reset_vals();
    sb.delete();
    mx    = 0;
    my    = 0;
    m_uf  = 1'b0;
    m_cnt = 16'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    en          = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = 12'h000;
    mx = 0; my = 0; m_uf = 1'b0; m_cnt = 16'd0;
    data_ctr = 12'h001; cyc = 0; de_cnt = 0; xfer_cnt = 0;

    // Reset state
    #1;
    chk_reset_vals();
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    // Three clean frames: de, transfer counts and frame_start period
    fs_times.delete();
    for (int f = 0; f < 3; f++) begin
      de_cnt   = 0;
      xfer_cnt = 0;
      repeat (128) cycle(1'b1, 1'b1);
      chk("de_per_frame", de_cnt, 32);
      chk("xfer_per_frame", xfer_cnt, 32);
    end
    chk("fs_count", fs_times.size(), 3);
    if (fs_times.size() >= 3) begin
      chk("fs_period0", fs_times[1] - fs_times[0], 128);
      chk("fs_period1", fs_times[2] - fs_times[1], 128);
    end

    // Starvation: three pixels missing at (2,1)
    run_to(2, 1);
    repeat (3) cycle(1'b1, 1'b0);
    chk("starve_rgb", {20'd0, b, g, r}, 0);
    chk("starve_de", de, 1);
    chk("starve_uf", underflow, 1);
`ifdef VGA_UNDERFLOW_CNT_EN
    chk("starve_cnt", underflow_cnt, 3);
`endif
    run_to(0, 0);
    chk("uf_held", underflow, 1);
    cycle(1'b1, 1'b1);
    chk("uf_clear_fs", frame_start, 1);
    chk("uf_cleared", underflow, 0);

    // Enable dropped at (5,2) for four cycles
    run_to(5, 2);
    repeat (4) begin
      cycle(1'b0, 1'b1);
      chk("en_low_de", de, 0);
      chk("en_low_hsync", hsync, 1);
    end
    cycle(1'b1, 1'b1);
    chk("en_rise_fs", frame_start, 1);
    chk("en_rise_x", x, 1);
    repeat (20) cycle(1'b1, 1'b1);

    // Reset mid-frame
    repeat (17) cycle(1'b1, 1'b1);
    mid_reset();
    cycle(1'b1, 1'b1);
    chk("post_rst_fs", frame_start, 1);
    repeat (130) cycle(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage. It replaces the fixed 640x480 sync logic with programmable horizontal and vertical timing, sync polarity and colour depth. It pulls pixels from an upstream pixel FIFO (the Avalon-side frame buffer path) through a ready/valid handshake and drives registered RGB, hsync and vsync to the DAC/pins. It detects FIFO starvation and blanks the affected pixels.

## Interface
Parameters:
- COLOR_DEPTH, 4, bits per colour channel
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted sync level (0 = active-low, 1 = active-high)
- VSYNC_POL, 0, asserted vsync level
- CNT_W, 12, width of the x/y counters; must satisfy 2^CNT_W > H_TOTAL and 2^CNT_W > V_TOTAL

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  run enable
- pixel_data  input  3*COLOR_DEPTH  {b,g,r}, with r in the LSBs
- pixel_valid  input  1  upstream pixel available
- pixel_ready  output  1  pixel consumed this cycle (combinational)
- r, g, b  output  COLOR_DEPTH each  registered colour
- hsync, vsync  output  1  registered sync
- de  output  1  registered data-enable (active video)
- frame_start  output  1  one-cycle pulse aligned with pixel (0,0) on the outputs
- x, y  output  CNT_W  current counter position (unregistered view of the counters)
- underflow  output  1  sticky starvation flag

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Horizontal counter x runs 0..H_TOTAL-1 and wraps to 0. On that wrap, y increments; y wraps 0 after V_TOTAL-1.
- The active region is x < H_ACTIVE && y < V_ACTIVE.
- hsync is asserted (HSYNC_POL) when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted (VSYNC_POL) when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. vsync changes only on line boundaries.
- pixel_ready = en && active. A transfer occurs when pixel_ready && pixel_valid.
- In an active cycle with pixel_valid low:
  - The pixel is starved and the output RGB for that position is 0.
  - underflow is set.
  - The raster does not stall.
- underflow clears only at reset or on the cycle frame_start is asserted. If starvation occurs on that same cycle, the set wins.
- Outside the active region, RGB = 0, de = 0 and pixel_data is ignored.
- en low:
  - Counters are synchronously forced to 0.
  - pixel_ready = 0.
  - Outputs go to the idle state (RGB 0, de 0, syncs deasserted).
- en rising: the raster restarts at (0,0) on the next cycle and frame_start fires.

## Timing
- Reset values:
  - x = y = 0
  - r = g = b = 0
  - de = 0, frame_start = 0, underflow = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
- Latency: hsync, vsync, de, rgb and frame_start reflect counter state (x,y) exactly one clk later, and all are mutually aligned.
- A pixel accepted in cycle N appears on r/g/b in cycle N+1.
- A frame is exactly H_TOTAL*V_TOTAL cycles. A line is exactly H_TOTAL cycles.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). After release, the raster starts at (0,0).

## Configuration
- VGA_UNDERFLOW_CNT_EN defined:
  - Adds output underflow_cnt [15:0]: a saturating count of starved pixels.
  - Cleared only by reset.
  - Increments by 1 on every starved active cycle and holds at 16'hFFFF.
- VGA_UNDERFLOW_CNT_EN undefined: the port and counter are absent. The sticky underflow flag is unaffected.

## Test plan
- Use a small config: H=8/2/3/3 (H_TOTAL 16) and V=4/1/2/1 (V_TOTAL 8), with pixel_valid held 1. Required: hsync low at x = 10..12 (delayed one cycle on the outputs), vsync low at y = 5..6, de high for 32 cycles per 128-cycle frame, and frame_start every 128 cycles.
- Feed an incrementing pixel_data = 12'h001 upward. Required: RGB on the outputs equals the accepted value one cycle later, reads 0 whenever de = 0, and exactly 32 transfers occur per frame.
- Drop pixel_valid for 3 active cycles at (2,1). Required: RGB = 0 for those 3 outputs, underflow = 1 until the next frame_start, and underflow_cnt = 3 when VGA_UNDERFLOW_CNT_EN is defined.
- Deassert en mid-line at (5,2) for 4 cycles, then reassert. Required: idle outputs and pixel_ready = 0 while en is low, then frame_start fires and the raster resumes from (0,0).
- Assert reset mid-frame. Required: all outputs take their reset values asynchronously, the raster restarts at (0,0) after release, and the first frame_start appears one cycle after release.
- Set HSYNC_POL = VSYNC_POL = 1. Required: syncs idle low and pulse high over the same x/y ranges.
